// File: rtl/link_ctrl.sv
// rtl/link_ctrl.sv - JESD link bring-up controller: SYSREF sequencing, LEMC alignment, PRBS enables and error counters
module link_ctrl #(
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_LANES-1:0]         tx_reset_done,
   input  logic [NUM_LANES-1:0]         rx_reset_done,
   input  logic                         lemc,
   input  logic [CNT_W-1:0]             cfg_sysref_period,
   input  logic [3:0]                   cfg_sysref_num,
   input  logic                         cfg_sysref_oneshot,
   input  logic                         cfg_sysref_disable,
   input  logic [NUM_LANES-1:0]         prbs_err,
   input  logic                         clr_err,
   output logic [NUM_LANES-1:0]         prbs_gen_en,
   output logic [NUM_LANES-1:0]         prbs_chk_en,
   output logic                         sysref,
   output logic                         sync,
   output logic [1:0]                   link_state,
   output logic [NUM_LANES*CNT_W-1:0]   err_cnt
);

   typedef enum logic [1:0] {
      S_WAIT_RST = 2'd0,
      S_SYSREF   = 2'd1,
      S_ALIGN    = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] per_cnt_nxt;
   logic [CNT_W-1:0] period;
   logic [3:0]       pulse_cnt;
   logic [3:0]       pulse_cnt_nxt;
   logic [3:0]       pulse_num;
   logic             all_done;
   logic             pulse_ok;
   logic             sysref_nxt;

   always_comb begin
      all_done  = (&tx_reset_done) & (&rx_reset_done);
      period    = (cfg_sysref_period == '0) ? CNT_W'(1) : cfg_sysref_period;
      pulse_num = (cfg_sysref_num == 4'd0) ? 4'd1 : cfg_sysref_num;

      state_nxt = state;
      case (state)
         S_WAIT_RST: begin
            if (all_done)
               state_nxt = cfg_sysref_disable ? S_ALIGN : S_SYSREF;
         end
         S_SYSREF: begin
            // sysref is the registered pulse, so this cycle is the pulse cycle
            if (cfg_sysref_disable)
               state_nxt = S_ALIGN;
            else if (sysref && (({1'b0, pulse_cnt} + 5'd1) >= {1'b0, pulse_num}))
               state_nxt = S_ALIGN;
         end
         S_ALIGN: begin
            if (lemc)
               state_nxt = S_RUN;
         end
         default: ;
      endcase
      if (state != S_WAIT_RST && !all_done)
         state_nxt = S_WAIT_RST;

      // A count above a lowered period misses the compare and wraps through all-ones
      per_cnt_nxt = (per_cnt == period) ? '0 : per_cnt + CNT_W'(1);
      if (state == S_WAIT_RST || state_nxt == S_WAIT_RST || cfg_sysref_disable)
         per_cnt_nxt = '0;

      pulse_cnt_nxt = pulse_cnt;
      if (state == S_WAIT_RST)
         pulse_cnt_nxt = 4'd0;
      else if (state == S_SYSREF && sysref)
         pulse_cnt_nxt = pulse_cnt + 4'd1;

      pulse_ok   = (state_nxt == S_SYSREF) ||
                   (!cfg_sysref_oneshot && state_nxt != S_WAIT_RST);
      sysref_nxt = pulse_ok && !cfg_sysref_disable && (per_cnt_nxt == period);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_WAIT_RST;
         per_cnt     <= '0;
         pulse_cnt   <= 4'd0;
         sysref      <= 1'b0;
         sync        <= 1'b0;
         prbs_gen_en <= '0;
         prbs_chk_en <= '0;
      end else begin
         state       <= state_nxt;
         per_cnt     <= per_cnt_nxt;
         pulse_cnt   <= pulse_cnt_nxt;
         sysref      <= sysref_nxt;
         sync        <= (state_nxt == S_RUN);
         prbs_gen_en <= {NUM_LANES{state_nxt == S_RUN}};
         prbs_chk_en <= {NUM_LANES{state_nxt == S_RUN}};
      end
   end

   assign link_state = state;

   // Error counts survive link aborts; only clr_err or reset clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (clr_err)
               err_cnt[i*CNT_W +: CNT_W] <= '0;
            else if (prbs_err[i] && prbs_chk_en[i] && !(&err_cnt[i*CNT_W +: CNT_W]))
               err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_link_ctrl.sv
// tb/tb_link_ctrl.sv - directed and randomized checks of link_ctrl against a behavioural model
module tb_link_ctrl;
   localparam int NL = 4;
   localparam int CW = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NL-1:0]    tx_done, rx_done;
   logic             lemc;
   logic [CW-1:0]    per;
   logic [3:0]       num;
   logic             oneshot, dis;
   logic [NL-1:0]    perr;
   logic             clr;
   logic [NL-1:0]    gen_en, chk_en;
   logic             sysref, sync;
   logic [1:0]       link_state;
   logic [NL*CW-1:0] err_cnt;

   link_ctrl #(.NUM_LANES(NL), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_reset_done(tx_done), .rx_reset_done(rx_done),
      .lemc(lemc),
      .cfg_sysref_period(per), .cfg_sysref_num(num),
      .cfg_sysref_oneshot(oneshot), .cfg_sysref_disable(dis),
      .prbs_err(perr), .clr_err(clr),
      .prbs_gen_en(gen_en), .prbs_chk_en(chk_en),
      .sysref(sysref), .sync(sync), .link_state(link_state),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model: link phase, SYSREF timeline position, pulses seen, error tallies
   int      m_st, m_cnt, m_pul;
   bit      m_sys;
   bit      m_en;
   int      m_err[NL];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_pul = 0; m_sys = 0; m_en = 0;
      for (int i = 0; i < NL; i++) m_err[i] = 0;
   endtask

   task automatic check_all();
      logic [NL*CW-1:0] exp_err;
      for (int i = 0; i < NL; i++) exp_err[i*CW +: CW] = CW'(m_err[i]);
      chk("m_state", link_state, m_st);
      chk("m_sysref", sysref, m_sys);
      chk("m_sync", sync, (m_st == 3));
      chk("m_gen_en", gen_en, m_en ? 4'hF : 4'h0);
      chk("m_chk_en", chk_en, m_en ? 4'hF : 4'h0);
      chk("m_err_cnt", err_cnt, exp_err);
   endtask

   task automatic step();
      bit ad, nsys;
      int p, n, ns, nc, np;
      ad = (&tx_done) && (&rx_done);
      p  = (per == 0) ? 1 : int'(per);
      n  = (num == 0) ? 1 : int'(num);
      case (m_st)
         0:       ns = ad ? (dis ? 2 : 1) : 0;
         1:       ns = dis ? 2 : ((m_sys && (m_pul + 1 >= n)) ? 2 : 1);
         2:       ns = lemc ? 3 : 2;
         default: ns = 3;
      endcase
      if (m_st != 0 && !ad) ns = 0;
      if (ns == 0 || m_st == 0 || dis) nc = 0;
      else nc = (m_cnt == p) ? 0 : (m_cnt + 1) % (1 << CW);
      np = (m_st == 0) ? 0 : ((m_st == 1 && m_sys) ? m_pul + 1 : m_pul);
      nsys = !dis && (ns != 0) && (ns == 1 || !oneshot) && (nc == p);
      for (int i = 0; i < NL; i++) begin
         if (clr) m_err[i] = 0;
         else if (perr[i] && m_en && m_err[i] < (1 << CW) - 1) m_err[i]++;
      end
      @(posedge clk);
      #1;
      m_st = ns; m_cnt = nc; m_pul = np; m_sys = nsys; m_en = (ns == 3);
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      rst_n = 1'b0; tx_done = '0; rx_done = '0; lemc = 1'b0;
      per = 4'd7; num = 4'd2; oneshot = 1'b0; dis = 1'b0; perr = '0; clr = 1'b0;
      model_reset();
      #12;
      chk("rst_state", link_state, 0);
      chk("rst_outs", {sysref, sync, gen_en, chk_en}, 0);
      chk("rst_err", err_cnt, 0);
      rst_n = 1'b1;
      run(3);

      // basic bring-up: P=7, N=2
      tx_done = '1; rx_done = '1;
      step();
      chk("bring_sysref_state", link_state, 1);
      for (int j = 1; j <= 16; j++) begin
         step();
         chk("bring_pulse", sysref, (j == 7 || j == 15));
      end
      chk("bring_align", link_state, 2);
      run(3);
      lemc = 1'b1; step(); lemc = 1'b0;
      chk("bring_run_state", link_state, 3);
      chk("bring_sync", sync, 1);
      chk("bring_gen_en", gen_en, 4'hF);
      chk("bring_chk_en", chk_en, 4'hF);
      for (int j = 1; j <= 12; j++) begin
         step();
         chk("run_pulse", sysref, (j == 3 || j == 11));
      end

      // disable raised in RUN
      dis = 1'b1; step();
      chk("dis_run_sysref", sysref, 0);
      run(10);
      dis = 1'b0;

      // lane abort, then restore with one-shot
      rx_done[2] = 1'b0; step();
      chk("abort_state", link_state, 0);
      chk("abort_sync", sync, 0);
      chk("abort_en", gen_en, 0);
      run(2);
      oneshot = 1'b1; rx_done[2] = 1'b1; step();
      chk("restore_sysref", link_state, 1);
      run(16);
      chk("oneshot_align", link_state, 2);
      for (int j = 0; j < 10; j++) begin step(); chk("oneshot_align_quiet", sysref, 0); end
      lemc = 1'b1; step(); lemc = 1'b0;
      for (int j = 0; j < 20; j++) begin step(); chk("oneshot_run_quiet", sysref, 0); end

      // SYSREF disabled from the start
      tx_done = '0; step();
      oneshot = 1'b0; dis = 1'b1; tx_done = '1; step();
      chk("dis_skip_align", link_state, 2);
      for (int j = 0; j < 20; j++) begin step(); chk("dis_quiet", sysref, 0); end
      dis = 1'b0;

      // period=0 and num=0 act as 1
      tx_done[1] = 1'b0; step();
      per = 4'd0; num = 4'd0; tx_done[1] = 1'b1; step();
      chk("p0_state", link_state, 1);
      step();
      chk("p0_first_pulse", sysref, 1);
      step();
      chk("n0_align", link_state, 2);
      for (int j = 1; j <= 6; j++) begin step(); chk("p0_every2", sysref, (j % 2 == 1)); end

      // lemc during SYSREF ignored
      tx_done[0] = 1'b0; step();
      per = 4'd5; num = 4'd3; tx_done[0] = 1'b1; step();
      lemc = 1'b1; run(3); lemc = 1'b0;
      chk("lemc_in_sysref", link_state, 1);
      run(15);
      chk("n3_align", link_state, 2);
      lemc = 1'b1; step(); lemc = 1'b0;
      chk("n3_run", link_state, 3);

      // error counters
      perr = 4'b0010; run(20); perr = '0; step();
      chk("err_sat", err_cnt, 16'h00F0);
      clr = 1'b1; perr = 4'b1111; step(); clr = 1'b0; perr = '0;
      chk("err_clr_prio", err_cnt, 16'h0000);
      perr = 4'b1000; run(3); perr = '0;
      chk("err_lane3", err_cnt, 16'h3000);
      tx_done[3] = 1'b0; step();
      chk("err_kept_abort", err_cnt, 16'h3000);
      perr = 4'b1111; run(3); perr = '0;
      chk("err_chk_off", err_cnt, 16'h3000);

      // asynchronous reset during SYSREF
      per = 4'd7; num = 4'd2; tx_done = '1; step();
      run(3);
      chk("pre_rst_state", link_state, 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_state", link_state, 0);
      chk("async_rst_outs", {sysref, sync, gen_en, chk_en}, 0);
      chk("async_rst_err", err_cnt, 0);
      #2 rst_n = 1'b1;
      chk("rst_release_state", link_state, 0);
      run(2);

      // randomized operation against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 49) == 0) per = CW'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) num = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) oneshot = ~oneshot;
         if ($urandom_range(0, 149) == 0) dis = ~dis;
         lemc = ($urandom_range(0, 7) == 0);
         perr = NL'($urandom);
         clr  = ($urandom_range(0, 39) == 0);
         if ((&tx_done) && (&rx_done)) begin
            if ($urandom_range(0, 149) == 0) rx_done[$urandom_range(0, NL-1)] = 1'b0;
            else if ($urandom_range(0, 299) == 0) tx_done[$urandom_range(0, NL-1)] = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            tx_done = '1; rx_done = '1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/link_ctrl.md
# link_ctrl

Parametrised JESD link bring-up controller for NUM_LANES lanes. It sequences per-lane reset completion, SYSREF generation (continuous, one-shot or disabled, with programmable period and pulse count), LEMC alignment, and PRBS generator/checker enables, and it keeps per-lane saturating PRBS error counters. It sits between the transceiver reset logic and the JTX/PRBS datapath, and replaces the fixed single-lane controller with hard-wired SYSREF period.

## Interface

Parameters:
- NUM_LANES, 4, number of lanes (1..16)
- CNT_W, 8, width of the SYSREF period counter and of each error counter

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous, active-low reset
- tx_reset_done  in  NUM_LANES  per-lane TX reset complete (level)
- rx_reset_done  in  NUM_LANES  per-lane RX reset complete (level)
- lemc  in  1  local multiframe clock strobe, one cycle wide
- cfg_sysref_period  in  CNT_W  SYSREF period minus one; 0 treated as 1
- cfg_sysref_num  in  4  SYSREF pulses before ALIGN; 0 treated as 1
- cfg_sysref_oneshot  in  1  no SYSREF pulses after leaving SYSREF state
- cfg_sysref_disable  in  1  SYSREF held low; SYSREF state skipped
- prbs_err  in  NUM_LANES  per-lane checker error strobe
- clr_err  in  1  synchronous clear of all error counters
- prbs_gen_en  out  NUM_LANES  per-lane PRBS generator enable
- prbs_chk_en  out  NUM_LANES  per-lane PRBS checker enable
- sysref  out  1  SYSREF pulse, one cycle wide
- sync  out  1  link synchronised (high in RUN)
- link_state  out  2  current state encoding
- err_cnt  out  NUM_LANES*CNT_W  lane i count in bits [i*CNT_W +: CNT_W]

## Operation

- All outputs are registered. Reset values: prbs_gen_en=0, prbs_chk_en=0, sysref=0, sync=0, link_state=WAIT_RST, err_cnt=0. Internal period counter and pulse counter reset to 0.
- all_done = &tx_reset_done & &rx_reset_done.
- States: WAIT_RST=0, SYSREF=1, ALIGN=2, RUN=3.
- WAIT_RST: if all_done, go to SYSREF; if cfg_sysref_disable is also high, go to ALIGN instead. Period and pulse counters are cleared.
- SYSREF: P = max(cfg_sysref_period,1). The period counter counts 0..P and wraps to 0. sysref is high in each cycle where the counter equals P, so the SYSREF period is P+1 cycles. The pulse counter increments on each pulse. On the Nth pulse (N = max(cfg_sysref_num,1)), the next state is ALIGN.
- ALIGN: the period counter keeps running. On lemc=1, go to RUN. In the same transition, prbs_gen_en and prbs_chk_en go to all ones.
- RUN: sync=1. sysref keeps pulsing with period P+1 unless cfg_sysref_oneshot or cfg_sysref_disable is set.
- Abort: in any state other than WAIT_RST, all_done=0 forces the next state to WAIT_RST. This has priority over every other transition. On abort, enables, sync and sysref are cleared next cycle.
- cfg_sysref_disable rising mid-operation:
  - sysref is low from the next cycle and the period counter is held at 0.
  - If the block is in SYSREF, it goes to ALIGN.
- Config inputs are sampled every cycle. Changing cfg_sysref_period while counting takes effect at the next compare and does not reset the counter. If the new P is below the current count, the counter runs to 2^CNT_W-1 and wraps.
- Error counters: lane i increments when prbs_err[i] && prbs_chk_en[i]. Counters saturate at 2^CNT_W-1. clr_err has priority over increment. Counters are not cleared by abort.

## Timing

- WAIT_RST to SYSREF: 1 cycle after all_done is sampled high.
- The first cycle in SYSREF is cycle T, with counter=0. Pulses occur at T+P, T+2P+1, … With P=7, pulses are at T+7 and T+15.
- Nth pulse at cycle S: state is ALIGN at S+1.
- lemc at cycle L while in ALIGN: state=RUN, sync=1 and enables=all ones at L+1. An lemc in any other state is ignored.
- all_done falls at cycle A: state=WAIT_RST and outputs cleared at A+1.
- prbs_err at cycle E: err_cnt is updated at E+1.
- rst_n assertion clears everything asynchronously. Operation resumes on the first clk edge after deassertion.

## Test plan

- Basic bring-up: NUM_LANES=4, period=7, num=2, all done at cycle 10 -> SYSREF at 11, sysref at 18 and 26, ALIGN at 27; lemc at 30 -> sync=1, enables=4'hF at 31; continuous sysref at 34, 42, …
- One-shot and disable: oneshot=1 -> no sysref after ALIGN. disable=1 with all done at cycle 10 -> ALIGN at 11, sysref never high. disable raised in RUN -> sysref low next cycle.
- Lane abort: rx_reset_done[2] drops in RUN -> WAIT_RST next cycle, enables=0, sync=0; restore -> full sequence repeats from SYSREF.
- Config edges: period=0 -> pulse every 2 cycles. num=0 -> ALIGN after 1 pulse. lemc during SYSREF -> ignored.
- Error counters: CNT_W=4, 20 prbs_err[1] strobes in RUN -> err_cnt lane1=15 (saturated), other lanes 0. prbs_err while chk_en=0 -> no count. clr_err together with prbs_err -> 0.
- Reset mid-operation: rst_n low during SYSREF -> all outputs at reset values immediately; after release -> WAIT_RST.
